// File: rtl/conv_sched_pkg.sv
// Shared types and config-field layout for the convolution job scheduler.
// The config word maps the requester cfg {sizeY, sizeX, shape} onto the core register.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        START,
        WAIT_BUSY,
        RUN,
        DRAIN
    } state_t;

    localparam int SHAPE_BIT = 1;
    localparam int SX_LSB    = 2;
    localparam int SY_LSB    = 7;
    localparam int CFG_W     = 11;
    localparam int SIZE_W    = 5;
    localparam int ZC_W      = 7;

    localparam logic [ZC_W-1:0] ZC_MAX = 7'd127;

    // Requester cfg bit 0 is shape, [5:1] sizeX, [10:6] sizeY.
    function automatic logic [31:0] cfg_to_reg(input logic [CFG_W-1:0] cfg);
        logic [31:0] r;
        r = '0;
        r[SHAPE_BIT]         = cfg[0];
        r[SX_LSB +: SIZE_W]  = cfg[SIZE_W:1];
        r[SY_LSB +: SIZE_W]  = cfg[2*SIZE_W:SIZE_W+1];
        return r;
    endfunction

endpackage

// File: rtl/conv_rr_arbiter.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
// The priority pointer only moves when the scheduler actually takes the grant.
module conv_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] winner
);

    // pri == 1 means requester 1 wins a tie
    logic pri;

    always_comb begin
        winner = 2'b00;
        unique case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = pri ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri <= 1'b0;
        end else if (accept && (winner != 2'b00)) begin
            pri <= winner[0];
        end
    end

endmodule

// File: rtl/conv_job_scheduler.sv
// Shares one convolution core between two requesters: grants, configures, starts,
// tracks the job to completion (or watchdog timeout) and reports the result per requester.
module conv_job_scheduler
    import conv_sched_pkg::*;
#(
    parameter int               TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_MAX = 16'd1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [CFG_W-1:0] req0_cfg,
    input  logic [CFG_W-1:0] req1_cfg,
    output logic [1:0]       gnt,
    output logic [1:0]       cmpl,
    output logic [1:0]       err,
    output logic [ZC_W-1:0]  zcount,
    output logic [31:0]      data_ConfigReg,
    output logic             start,
    input  logic             busy_i,
    input  logic             done_i,
    input  logic             writeZ_i
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       req_eff;
    logic [1:0]       winner;
    logic             active;
    logic             size_ok;
    logic             timeout;
    logic             fin_ok;
    logic             fin_err;
    logic [TMO_W-1:0] wdog;
    logic [TMO_W-1:0] wdog_inc;

    // A requester still holds req during its own cmpl/err cycle; it must not be re-granted then.
    assign req_eff  = req & ~(cmpl | err);
    assign active   = (state == WAIT_BUSY) || (state == RUN) || (state == DRAIN);
    assign size_ok  = (data_ConfigReg[SX_LSB +: SIZE_W] != '0) &&
                      (data_ConfigReg[SY_LSB +: SIZE_W] != '0);
    assign wdog_inc = wdog + 1'b1;
    assign timeout  = active && (wdog_inc == TMO_MAX);
    assign start    = (state == START);

    conv_rr_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_eff),
        .accept (state == IDLE),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fin_ok    = 1'b0;
        fin_err   = 1'b0;
        unique case (state)
            IDLE:      if (|req_eff) state_nxt = CFG;
            CFG: begin
                if (!size_ok) begin
                    fin_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = START;
                end
            end
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (busy_i) state_nxt = RUN;
            RUN:       if (done_i) state_nxt = DRAIN;
            DRAIN: begin
                if (!busy_i && !done_i) begin
                    fin_ok    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default:   state_nxt = IDLE;
        endcase
        // Watchdog expiry overrides any completion seen in the same cycle.
        if (timeout) begin
            fin_ok    = 1'b0;
            fin_err   = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt            <= 2'b00;
            cmpl           <= 2'b00;
            err            <= 2'b00;
            zcount         <= '0;
            data_ConfigReg <= '0;
            wdog           <= '0;
        end else begin
            cmpl <= fin_ok  ? gnt : 2'b00;
            err  <= fin_err ? gnt : 2'b00;
            // gnt is held through the result pulse and only moves while idle
            if (state == IDLE) begin
                gnt <= winner;
                if (|winner) begin
                    data_ConfigReg <= cfg_to_reg(winner[1] ? req1_cfg : req0_cfg);
                end
            end
            if (state == START) begin
                wdog <= '0;
            end else if (active) begin
                wdog <= wdog_inc;
            end
            if ((state == IDLE) && (|winner)) begin
                zcount <= '0;
            end else if (active && writeZ_i && (zcount != ZC_MAX)) begin
                zcount <= zcount + 1'b1;
            end
        end
    end

endmodule

// File: doc/conv_job_scheduler.md
CONV_JOB_SCHEDULER -- requirements
Module: conv_job_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TMO_W, 16, width of the watchdog counter.
- TMO_MAX, 16'd1000, watchdog limit in cycles.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning (clock and reset first).
- clk, in, 1, the single clock.
- rst_n, in, 1, asynchronous active-low reset.
- req, in, 2, per-requester job request; level, held until cmpl or err.
- req0_cfg, in, 11, {sizeY[4:0], sizeX[4:0], shape}; sampled at grant.
- req1_cfg, in, 11, same layout, requester 1.
- gnt, out, 2, one-hot owner of the convolution core.
- cmpl, out, 2, one-cycle job-complete pulse per requester.
- err, out, 2, one-cycle job-failed pulse per requester.
- zcount, out, 7, writeZ pulses counted during the last job.
- data_ConfigReg, out, 32, core config: bit1 shape, [6:2] sizeX, [11:7] sizeY, others 0.
- start, out, 1, core start pulse.
- busy_i, in, 1, core status_IPcore[0].
- done_i, in, 1, core int_IPcore[0].
- writeZ_i, in, 1, core Z write strobe.

Function
REQ-003 The FSM SHALL have states IDLE, CFG, START, WAIT_BUSY, RUN, DRAIN.
REQ-004 IDLE with any req bit set SHALL go to CFG next cycle, set gnt to the arbiter winner, load data_ConfigReg from the winner's cfg, and clear zcount.
REQ-005 Arbitration SHALL be 2-way round-robin: on simultaneous requests the requester not granted last wins; after reset requester 0 has priority.
REQ-006 In CFG, if sizeX==0 or sizeY==0, the block SHALL pulse err for the owner, clear gnt, and return to IDLE without asserting start.
REQ-007 Otherwise CFG SHALL go to START, so data_ConfigReg is stable at least one cycle before start.
REQ-008 START SHALL assert start for exactly one cycle, then enter WAIT_BUSY.
REQ-009 WAIT_BUSY SHALL go to RUN when busy_i==1.
REQ-010 RUN SHALL go to DRAIN on the first cycle with done_i==1.
REQ-011 DRAIN SHALL wait for busy_i==0 and done_i==0, then pulse cmpl for the owner, clear gnt, and return to IDLE.
REQ-012 Latency: req seen in IDLE at cycle n gives gnt at n+1 and start at n+2; cmpl comes no earlier than one cycle after done_i falls.
REQ-013 zcount SHALL increment on each writeZ_i while in WAIT_BUSY, RUN or DRAIN, saturate at 127, and hold until the next grant.
REQ-014 A watchdog SHALL count cycles spent in WAIT_BUSY, RUN or DRAIN and clear on entering WAIT_BUSY.
REQ-015 When the watchdog reaches TMO_MAX, the block SHALL pulse err instead of cmpl, clear gnt, and return to IDLE.
REQ-016 gnt SHALL never change while the FSM is outside IDLE.
REQ-017 If the owner drops req mid-job, the job SHALL still run to cmpl or err.
REQ-018 cmpl and err SHALL never be asserted in the same cycle, and SHALL never be asserted for a non-owner.
REQ-019 start SHALL never be asserted outside START.

Reset
REQ-020 While rst_n==0 the block SHALL go to IDLE asynchronously and hold gnt, cmpl, err, start, zcount, data_ConfigReg, the watchdog and the round-robin pointer at 0.
REQ-021 A reset mid-job SHALL abort without issuing cmpl or err.
REQ-022 Reset release SHALL take effect on the first clk edge after rst_n rises.

Structure
REQ-023 Package conv_sched_pkg SHALL hold:
- the state enum;
- config bit positions: SHAPE_BIT=1, SX_LSB=2, SY_LSB=7;
- CFG_W=11.
REQ-024 One sub-module, conv_rr_arbiter, SHALL hold the 2-way round-robin winner logic and pointer; everything else stays in conv_job_scheduler.

Verification
REQ-025 Single job: req=01, req0_cfg {sizeY=4, sizeX=3, shape=0}; core model raises busy 2 cycles after start, emits 6 writeZ, then done. Required: gnt=01 at n+1; data_ConfigReg=0x20C; start one cycle at n+2; cmpl=01 once; zcount=6.
REQ-026 Contention: req=11 held for two jobs. Required: grant order requester 0 then requester 1; never both gnt bits set; one cmpl per requester.
REQ-027 Zero size: req1_cfg sizeX=0. Required: err=10 pulse at n+2; start never asserted; gnt=00 at n+3.
REQ-028 Watchdog: TMO_MAX=20 and the core never raises busy. Required: err pulse exactly 20 cycles after entering WAIT_BUSY; FSM returns to IDLE.
REQ-029 Reset during RUN. Required: all outputs 0 immediately; no cmpl/err; a later req=01 is served normally.
REQ-030 Owner drops req mid-RUN. Required: cmpl still issued; saturation check with 130 writeZ gives zcount=127.
